// File: rtl/cory_axi_pkg.sv
// Shared encodings for the cory AXI responder: channel FSM states, response code and
// the byte-offset width helper.
package cory_axi_pkg;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  localparam logic [1:0] RespOkay = 2'b00;

  // Number of low address bits that select a byte within one data word.
  function automatic int unsigned word_off_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/cory_axi_mem_ram.sv
// Word array for cory_axi_mem: one synchronous write port and one synchronous read port.
// A same-cycle write and read of one address returns the pre-write word.
module cory_axi_mem_ram #(
  parameter int unsigned D = 64,
  parameter int unsigned M = 10
) (
  input  logic         clk,
  input  logic         we,
  input  logic [M-1:0] waddr,
  input  logic [D-1:0] wdata,
  input  logic         re,
  input  logic [M-1:0] raddr,
  output logic [D-1:0] rdata
);

  logic [D-1:0] mem [2**M];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cory_axi_mem.sv
// AXI responder backed by an internal word array: INCR write bursts on aw/w/b and read
// bursts on ar/r, the two channels running independently.
module cory_axi_mem
  import cory_axi_pkg::*;
#(
  parameter int unsigned A = 32,
  parameter int unsigned L = 4,
  parameter int unsigned D = 64,
  parameter int unsigned M = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_awvalid,
  input  logic [A-1:0] i_awaddr,
  input  logic [L-1:0] i_awlen,
  output logic         o_awready,
  input  logic         i_wvalid,
  input  logic [D-1:0] i_wdata,
  input  logic         i_wlast,
  output logic         o_wready,
  output logic         o_bvalid,
  input  logic         i_bready,
  input  logic         i_arvalid,
  input  logic [A-1:0] i_araddr,
  input  logic [L-1:0] i_arlen,
  output logic         o_arready,
  output logic         o_rvalid,
  output logic [D-1:0] o_rdata,
  output logic         o_rlast,
  input  logic         i_rready,
  output logic         o_busy,
  output logic         o_err
);

  localparam int unsigned Off = word_off_bits(D);

  w_state_e     w_state_q, w_state_d;
  r_state_e     r_state_q, r_state_d;
  logic [M-1:0] widx_q, widx_d, ridx_q, ridx_d;
  logic [L-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic         err_q, err_d, busy_q;

  logic         ram_we, ram_re;
  logic [M-1:0] ram_raddr;
  logic [D-1:0] ram_rdata;
  logic [M-1:0] aw_idx, ar_idx;

  // Byte-lane and upper address bits carry no meaning for a word array.
  logic unused_addr;
  assign unused_addr = ^{i_awaddr, i_araddr};

  assign aw_idx = i_awaddr[Off+M-1:Off];
  assign ar_idx = i_araddr[Off+M-1:Off];

  always_comb begin
    w_state_d = w_state_q;
    widx_d    = widx_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (i_awvalid) begin
          widx_d    = aw_idx;
          wcnt_d    = i_awlen;
          w_state_d = WData;
        end
      end
      WData: begin
        if (i_wvalid) begin
          ram_we = 1'b1;
          if (i_wlast != (wcnt_q == '0)) err_d = 1'b1;
          // Burst length comes from awlen; a misplaced wlast only flags the error.
          if (wcnt_q == '0) begin
            w_state_d = WResp;
          end else begin
            widx_d = widx_q + 1'b1;
            wcnt_d = wcnt_q - 1'b1;
          end
        end
      end
      WResp: begin
        if (i_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    ridx_d    = ridx_q;
    rcnt_d    = rcnt_q;
    ram_re    = 1'b0;
    ram_raddr = ridx_q;
    unique case (r_state_q)
      RIdle: begin
        if (i_arvalid) begin
          ridx_d    = ar_idx;
          rcnt_d    = i_arlen;
          ram_re    = 1'b1;
          ram_raddr = ar_idx;
          r_state_d = RData;
        end
      end
      RData: begin
        if (i_rready) begin
          if (rcnt_q == '0) begin
            r_state_d = RIdle;
          end else begin
            // Prefetch the next word on the handshake so beats stay back to back.
            ridx_d    = ridx_q + 1'b1;
            rcnt_d    = rcnt_q - 1'b1;
            ram_re    = 1'b1;
            ram_raddr = ridx_q + 1'b1;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      widx_q    <= '0;
      wcnt_q    <= '0;
      ridx_q    <= '0;
      rcnt_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
      ridx_q    <= ridx_d;
      rcnt_q    <= rcnt_d;
      err_q     <= err_d;
      busy_q    <= (w_state_d != WIdle) | (r_state_d != RIdle);
    end
  end

  cory_axi_mem_ram #(
    .D(D),
    .M(M)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(widx_q),
    .wdata(i_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign o_awready = (w_state_q == WIdle);
  assign o_wready  = (w_state_q == WData);
  assign o_bvalid  = (w_state_q == WResp);
  assign o_arready = (r_state_q == RIdle);
  assign o_rvalid  = (r_state_q == RData);
  assign o_rlast   = o_rvalid && (rcnt_q == '0);
  // The array read register is not reset, so gate it to keep rdata at zero when idle.
  assign o_rdata   = o_rvalid ? ram_rdata : '0;
  assign o_busy    = busy_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_cory_axi_mem.sv
// Directed bench for cory_axi_mem: bursts, wrap, back-pressure, wlast error, collision, reset.
module tb_cory_axi_mem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_awvalid = 1'b0;
  logic [31:0] i_awaddr = '0;
  logic [3:0]  i_awlen = '0;
  logic        o_awready;
  logic        i_wvalid = 1'b0;
  logic [63:0] i_wdata = '0;
  logic        i_wlast = 1'b0;
  logic        o_wready;
  logic        o_bvalid;
  logic        i_bready = 1'b1;
  logic        i_arvalid = 1'b0;
  logic [31:0] i_araddr = '0;
  logic [3:0]  i_arlen = '0;
  logic        o_arready;
  logic        o_rvalid;
  logic [63:0] o_rdata;
  logic        o_rlast;
  logic        i_rready = 1'b0;
  logic        o_busy;
  logic        o_err;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] wbuf [16];
  logic [63:0] rbuf [16];

  cory_axi_mem dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_awvalid(i_awvalid),
    .i_awaddr (i_awaddr),
    .i_awlen  (i_awlen),
    .o_awready(o_awready),
    .i_wvalid (i_wvalid),
    .i_wdata  (i_wdata),
    .i_wlast  (i_wlast),
    .o_wready (o_wready),
    .o_bvalid (o_bvalid),
    .i_bready (i_bready),
    .i_arvalid(i_arvalid),
    .i_araddr (i_araddr),
    .i_arlen  (i_arlen),
    .o_arready(o_arready),
    .o_rvalid (o_rvalid),
    .o_rdata  (o_rdata),
    .o_rlast  (o_rlast),
    .i_rready (i_rready),
    .o_busy   (o_busy),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Writes wbuf[0..len] starting at addr; wlast is driven on beat last_beat.
  task automatic write_burst(input logic [31:0] addr, input int len, input int last_beat);
    int k;
    @(negedge clk);
    i_awvalid = 1'b1; i_awaddr = addr; i_awlen = len[3:0];
    k = 0;
    while (!o_awready && k < 20) begin @(negedge clk); k++; end
    if (k == 20) check("aw_timeout", 64'd0, 64'd1);
    @(negedge clk);
    i_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      i_wvalid = 1'b1; i_wdata = wbuf[b]; i_wlast = (b == last_beat);
      k = 0;
      while (!o_wready && k < 20) begin @(negedge clk); k++; end
      if (k == 20) check("w_timeout", 64'd0, 64'd1);
      @(negedge clk);
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    check("bvalid", 64'(o_bvalid), 64'd1);
    check("wready_off", 64'(o_wready), 64'd0);
    @(negedge clk);
    check("bvalid_drop", 64'(o_bvalid), 64'd0);
    check("awready_back", 64'(o_awready), 64'd1);
  endtask

  // Reads len+1 beats from addr and compares against rbuf; toggle alternates rready 0/1.
  task automatic read_burst(input logic [31:0] addr, input int len, input bit toggle);
    int k, got, cyc;
    bit held;
    logic [63:0] hold_val;
    @(negedge clk);
    i_arvalid = 1'b1; i_araddr = addr; i_arlen = len[3:0]; i_rready = 1'b0;
    k = 0;
    while (!o_arready && k < 20) begin @(negedge clk); k++; end
    if (k == 20) check("ar_timeout", 64'd0, 64'd1);
    @(negedge clk);
    i_arvalid = 1'b0;
    got = 0; cyc = 0; held = 1'b0; hold_val = '0;
    while (got <= len && cyc < 100) begin
      if (held) begin
        check("r_hold_valid", 64'(o_rvalid), 64'd1);
        check("r_hold_data", o_rdata, hold_val);
      end
      i_rready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (!toggle) check("r_valid", 64'(o_rvalid), 64'd1);
      if (o_rvalid && i_rready) begin
        check("r_data", o_rdata, rbuf[got]);
        check("r_last", 64'(o_rlast), 64'(got == len));
        got++;
        held = 1'b0;
      end else begin
        held = o_rvalid;
        hold_val = o_rdata;
      end
      cyc++;
      @(negedge clk);
    end
    i_rready = 1'b0;
    if (got <= len) check("r_timeout", 64'(got), 64'(len + 1));
    check("r_valid_drop", 64'(o_rvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_awready", 64'(o_awready), 64'd1);
    check("rst_arready", 64'(o_arready), 64'd1);
    check("rst_wready", 64'(o_wready), 64'd0);
    check("rst_bvalid", 64'(o_bvalid), 64'd0);
    check("rst_rvalid", 64'(o_rvalid), 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    check("rst_rlast", 64'(o_rlast), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b0;

    // 1: four-beat write at 0x100
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    write_burst(32'h100, 3, 3);
    check("t1_err", 64'(o_err), 64'd0);

    // 2: read it back at full rate
    rbuf[0] = 64'h11; rbuf[1] = 64'h22; rbuf[2] = 64'h33; rbuf[3] = 64'h44;
    read_burst(32'h100, 3, 1'b0);

    // 3: sixteen beats read with rready toggling
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 16 + 7);
      rbuf[i] = wbuf[i];
    end
    write_burst(32'h400, 15, 15);
    read_burst(32'h400, 15, 1'b1);

    // 5: wlast on beat 2 of 4 flags err, burst still runs to four beats
    wbuf[0] = 64'hA1; wbuf[1] = 64'hA2; wbuf[2] = 64'hA3; wbuf[3] = 64'hA4;
    write_burst(32'h800, 3, 1);
    check("t5_err", 64'(o_err), 64'd1);
    rbuf[0] = 64'hA1; rbuf[1] = 64'hA2; rbuf[2] = 64'hA3; rbuf[3] = 64'hA4;
    read_burst(32'h800, 3, 1'b0);

    // 4: write at index 1023 wraps to index 0
    wbuf[0] = 64'hDEAD_BEEF_0000_0001; wbuf[1] = 64'hDEAD_BEEF_0000_0002;
    write_burst(32'h1FF8, 1, 1);
    rbuf[0] = 64'hDEAD_BEEF_0000_0002;
    read_burst(32'h0, 0, 1'b0);
    rbuf[0] = 64'hDEAD_BEEF_0000_0001; rbuf[1] = 64'hDEAD_BEEF_0000_0002;
    read_burst(32'h1FF8, 1, 1'b0);
    check("t4_err_sticky", 64'(o_err), 64'd1);

    // 6: same-cycle write and fetch of index 50 returns old data
    wbuf[0] = 64'hAAAA;
    write_burst(32'h190, 0, 0);
    @(negedge clk);
    i_awvalid = 1'b1; i_awaddr = 32'h190; i_awlen = 4'd0;
    @(negedge clk);
    i_awvalid = 1'b0;
    i_wvalid = 1'b1; i_wdata = 64'hBBBB; i_wlast = 1'b1;
    i_arvalid = 1'b1; i_araddr = 32'h190; i_arlen = 4'd0; i_rready = 1'b0;
    check("coll_wready", 64'(o_wready), 64'd1);
    check("coll_arready", 64'(o_arready), 64'd1);
    @(negedge clk);
    i_wvalid = 1'b0; i_wlast = 1'b0; i_arvalid = 1'b0;
    check("coll_rvalid", 64'(o_rvalid), 64'd1);
    check("coll_old", o_rdata, 64'hAAAA);
    check("coll_bvalid", 64'(o_bvalid), 64'd1);
    @(negedge clk);
    check("coll_busy", 64'(o_busy), 64'd1);
    check("coll_hold", o_rdata, 64'hAAAA);
    #2 reset_n = 1'b1;
    #1;
    check("arst_rvalid", 64'(o_rvalid), 64'd0);
    check("arst_arready", 64'(o_arready), 64'd1);
    check("arst_busy", 64'(o_busy), 64'd0);
    check("arst_err", 64'(o_err), 64'd0);
    @(negedge clk);
    reset_n = 1'b0;
    rbuf[0] = 64'hBBBB;
    read_burst(32'h190, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
